z80_mem_responder: RTL and testbench

- Memory-side responder for the Z80 CPU bus: the far end of the memory read/write cycles the core issues for instructions such as LD (BC/DE),A and LD A,(BC/DE).
- Decodes MREQ/RD/WR/M1/RFSH, inserts configurable wait states, serves reads from an internal byte array and commits writes to it.
- Publishes the last committed write (address/data) for formal and simulation checkers alongside the z80fi spec modules.

---
 rtl/z80_mem_pkg.sv | 15 +
 rtl/z80_mem_responder_if.sv | 27 ++
 rtl/z80_mem_array.sv | 28 ++
 rtl/z80_mem_responder.sv | 139 +++++++++++++
 tb/tb_z80_mem_responder.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/z80_mem_pkg.sv
// z80_mem_pkg: shared types and constants for the Z80 memory responder.
// FSM encoding, data bus reset value and wait-counter width.
package z80_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER,
    HOLD
  } state_e;

  localparam logic [7:0] DIN_RST = 8'hFF;
  localparam int WCNT_W = 4;

endpackage

// File: rtl/z80_mem_responder_if.sv
// z80_mem_responder_if: Z80 CPU memory bus as seen by a memory device.
// master = CPU side, slave = memory responder side.
interface z80_mem_responder_if;

  logic        mreq_n;
  logic        rd_n;
  logic        wr_n;
  logic        m1_n;
  logic        rfsh_n;
  logic [15:0] addr;
  logic [7:0]  data_out;
  logic [7:0]  data_in;
  logic        wait_n;

  modport master (
    output mreq_n, rd_n, wr_n, m1_n, rfsh_n,
    output addr, data_out,
    input  data_in, wait_n
  );

  modport slave (
    input  mreq_n, rd_n, wr_n, m1_n, rfsh_n,
    input  addr, data_out,
    output data_in, wait_n
  );

endinterface

// File: rtl/z80_mem_array.sv
// z80_mem_array: byte RAM, async read, preload plus bus write port.
// A bus write to the same index as a preload in one cycle wins.
module z80_mem_array #(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [7:0]           wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [7:0]           rdata
);

  logic [7:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (load_en)
      mem[load_addr] <= load_data;
    if (we)
      mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/z80_mem_responder.sv
// z80_mem_responder: Z80 memory-side responder with wait states.
// Optional write protect below ROM_TOP: Z80_MEM_ROM_PROTECT_EN.
module z80_mem_responder
  import z80_mem_pkg::*;
#(
  parameter int          ADDR_BITS      = 12,
  parameter int          WAIT_STATES    = 0,
  parameter int          M1_WAIT_STATES = 0,
  parameter logic [15:0] ROM_TOP        = 16'h0100
) (
  input  logic        clk,
  input  logic        reset_n,
  z80_mem_responder_if.slave bus,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [7:0]  load_data,
  output logic        rd_strobe,
  output logic        wr_strobe,
  output logic [15:0] last_waddr,
  output logic [7:0]  last_wdata,
  output logic        proto_err
);

  localparam logic [WCNT_W-1:0] WS =
    WCNT_W'(WAIT_STATES);
  localparam logic [WCNT_W-1:0] M1WS =
    WCNT_W'(M1_WAIT_STATES);

  state_e            state;
  logic [WCNT_W-1:0] cnt;
  logic [WCNT_W-1:0] ld_cnt;
  logic [15:0]       a_q;
  logic              wr_q;
  logic [7:0]        data_q;
  logic [7:0]        mem_rd;
  logic              wait_q;
  logic              rom_hit;
  logic              bus_we;
  logic              unused_hi;

`ifdef Z80_MEM_ROM_PROTECT_EN
  assign rom_hit = wr_q && (a_q < ROM_TOP);
`else
  logic unused_rom;
  assign unused_rom = ^ROM_TOP;
  assign rom_hit = 1'b0;
`endif

  assign unused_hi = ^load_addr;
  assign ld_cnt = bus.m1_n ? WS : M1WS;

  assign bus_we = (state == XFER) && wr_q
                  && !rom_hit;
  assign rd_strobe = (state == XFER) && !wr_q;
  assign wr_strobe = bus_we;

  // read data is live only in XFER, then held
  assign bus.data_in = rd_strobe ? mem_rd
                                 : data_q;
  assign bus.wait_n = wait_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      a_q        <= '0;
      wr_q       <= 1'b0;
      data_q     <= DIN_RST;
      wait_q     <= 1'b1;
      last_waddr <= '0;
      last_wdata <= '0;
      proto_err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!bus.mreq_n && bus.rfsh_n) begin
            if (!bus.rd_n && !bus.wr_n) begin
              proto_err <= 1'b1;
              state     <= HOLD;
            end else if (bus.rd_n != bus.wr_n) begin
              a_q  <= bus.addr;
              wr_q <= !bus.wr_n;
              cnt  <= ld_cnt;
              if (ld_cnt == '0) begin
                state <= XFER;
              end else begin
                state  <= WAIT;
                wait_q <= 1'b0;
              end
            end
          end
        end
        WAIT: begin
          if (bus.mreq_n) begin
            state     <= IDLE;
            wait_q    <= 1'b1;
            proto_err <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == 1) begin
              state  <= XFER;
              wait_q <= 1'b1;
            end
          end
        end
        XFER: begin
          state <= HOLD;
          if (!wr_q) begin
            data_q <= mem_rd;
          end else if (rom_hit) begin
            proto_err <= 1'b1;
          end else begin
            last_waddr <= a_q;
            last_wdata <= bus.data_out;
          end
        end
        HOLD: begin
          if (bus.mreq_n)
            state <= IDLE;
        end
      endcase
    end
  end

  z80_mem_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_mem (
    .clk      (clk),
    .load_en  (load_en),
    .load_addr(load_addr[ADDR_BITS-1:0]),
    .load_data(load_data),
    .we       (bus_we),
    .waddr    (a_q[ADDR_BITS-1:0]),
    .wdata    (bus.data_out),
    .raddr    (a_q[ADDR_BITS-1:0]),
    .rdata    (mem_rd)
  );

endmodule

// File: tb/tb_z80_mem_responder.sv
// tb_z80_mem_responder: two responders (0/0 and 2/1 wait states)
// driven by a transaction-level CPU model with a byte-array reference.
module tb_z80_mem_responder;

  localparam int AB = 12;
  localparam int N = 1 << AB;
  localparam logic [15:0] RT = 16'h0100;
`ifdef Z80_MEM_ROM_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        mreq_n[2], rd_n[2], wr_n[2];
  logic        m1_n[2], rfsh_n[2];
  logic [15:0] addr[2];
  logic [7:0]  dout[2];
  logic [7:0]  din[2];
  logic        wn[2];
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;
  logic        rs[2], ws[2], pe[2];
  logic [15:0] lwa[2];
  logic [7:0]  lwd[2];

  z80_mem_responder_if ia ();
  z80_mem_responder_if ib ();

  assign ia.mreq_n   = mreq_n[0];
  assign ia.rd_n     = rd_n[0];
  assign ia.wr_n     = wr_n[0];
  assign ia.m1_n     = m1_n[0];
  assign ia.rfsh_n   = rfsh_n[0];
  assign ia.addr     = addr[0];
  assign ia.data_out = dout[0];
  assign din[0]      = ia.data_in;
  assign wn[0]       = ia.wait_n;
  assign ib.mreq_n   = mreq_n[1];
  assign ib.rd_n     = rd_n[1];
  assign ib.wr_n     = wr_n[1];
  assign ib.m1_n     = m1_n[1];
  assign ib.rfsh_n   = rfsh_n[1];
  assign ib.addr     = addr[1];
  assign ib.data_out = dout[1];
  assign din[1]      = ib.data_in;
  assign wn[1]       = ib.wait_n;

  z80_mem_responder #(
    .ADDR_BITS(AB), .WAIT_STATES(0),
    .M1_WAIT_STATES(0), .ROM_TOP(RT)
  ) u0 (
    .clk(clk), .reset_n(rst_n), .bus(ia),
    .load_en(ld_en), .load_addr(ld_addr),
    .load_data(ld_data),
    .rd_strobe(rs[0]), .wr_strobe(ws[0]),
    .last_waddr(lwa[0]), .last_wdata(lwd[0]),
    .proto_err(pe[0])
  );

  z80_mem_responder #(
    .ADDR_BITS(AB), .WAIT_STATES(2),
    .M1_WAIT_STATES(1), .ROM_TOP(RT)
  ) u1 (
    .clk(clk), .reset_n(rst_n), .bus(ib),
    .load_en(ld_en), .load_addr(ld_addr),
    .load_data(ld_data),
    .rd_strobe(rs[1]), .wr_strobe(ws[1]),
    .last_waddr(lwa[1]), .last_wdata(lwd[1]),
    .proto_err(pe[1])
  );

  // reference model
  logic [7:0]  mdl[2][N];
  logic [15:0] m_lwa[2];
  logic [7:0]  m_lwd[2];
  logic        m_pe[2];

  int n_run = 0;
  int n_fail = 0;

  function automatic int exp_waits(int d, bit m1);
    if (d == 0) return 0;
    return m1 ? 1 : 2;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic bus_idle(input int d);
    mreq_n[d] = 1'b1;
    rd_n[d]   = 1'b1;
    wr_n[d]   = 1'b1;
    m1_n[d]   = 1'b1;
    rfsh_n[d] = 1'b1;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_lwa[d] = '0;
      m_lwd[d] = '0;
      m_pe[d]  = 1'b0;
    end
  endtask

  task automatic chk_regs(input int d);
    chk("last_waddr", lwa[d], m_lwa[d]);
    chk("last_wdata", lwd[d], m_lwd[d]);
    chk("proto_err", pe[d], m_pe[d]);
  endtask

  // one full bus cycle; xld loads xd to the same address in XFER
  task automatic cycle(input int d, input bit wr,
                       input bit m1,
                       input logic [15:0] a,
                       input logic [7:0] wd,
                       input bit xld,
                       input logic [7:0] xd,
                       input int ew,
                       input logic [7:0] erd);
    logic [AB-1:0] idx;
    bit prot, done;
    int w;
    idx  = a[AB-1:0];
    prot = wr && PROT && (a < RT);
    @(posedge clk); #1;
    addr[d]   = a;
    dout[d]   = wd;
    m1_n[d]   = !m1;
    rd_n[d]   = wr;
    wr_n[d]   = !wr;
    rfsh_n[d] = 1'b1;
    mreq_n[d] = 1'b0;
    w = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk); #1;
      if (!wn[d]) w++;
      else done = 1'b1;
    end
    if (!done) begin
      n_run++;
      n_fail++;
      $display("FAIL timeout: dut%0d addr %h", d, a);
    end else begin
      chk("wait_count", w, ew);
      chk("rd_strobe", rs[d], !wr);
      chk("wr_strobe", ws[d], wr && !prot);
      if (!wr) chk("read_data", din[d], erd);
      if (xld) begin
        ld_addr = a;
        ld_data = xd;
        ld_en   = 1'b1;
        #1;
        if (!wr) chk("read_vs_load", din[d], erd);
      end
      @(posedge clk); #1;
      ld_en = 1'b0;
      chk("hold_strobes", {rs[d], ws[d]}, 0);
      chk("hold_wait_n", wn[d], 1);
      if (!wr) chk("hold_data", din[d], erd);
    end
    if (xld) begin
      mdl[0][idx] = xd;
      mdl[1][idx] = xd;
    end
    if (wr && !prot) begin
      mdl[d][idx] = wd;
      m_lwa[d] = a;
      m_lwd[d] = wd;
    end
    if (prot) m_pe[d] = 1'b1;
    bus_idle(d);
    @(posedge clk); #1;
    chk_regs(d);
  endtask

  typedef struct {
    int          d;
    bit          wr;
    bit          m1;
    logic [15:0] a;
    logic [7:0]  wd;
    int          ew;
    logic [7:0]  erd;
  } vec_t;

  vec_t tv[9];

  initial begin
    logic [7:0] old;
    int d;
    bit wr, m1, xld;
    logic [15:0] a;
    logic [7:0] wd, xd;

    tv[0] = '{0, 0, 0, 16'h0123, 8'h00, 0, 8'h5A};
    tv[1] = '{1, 0, 0, 16'h0123, 8'h00, 2, 8'h5A};
    tv[2] = '{1, 1, 0, 16'h0456, 8'hC3, 2, 8'h00};
    tv[3] = '{1, 0, 0, 16'h0456, 8'h00, 2, 8'hC3};
    tv[4] = '{1, 0, 1, 16'h0456, 8'h00, 1, 8'hC3};
    tv[5] = '{0, 1, 0, 16'h0789, 8'h3C, 0, 8'h00};
    tv[6] = '{0, 0, 1, 16'h1789, 8'h00, 0, 8'h3C};
    tv[7] = '{1, 1, 0, 16'hF456, 8'h77, 2, 8'h00};
    tv[8] = '{1, 0, 0, 16'h0456, 8'h00, 2, 8'h77};

    rst_n = 1'b0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    for (int i = 0; i < 2; i++) begin
      bus_idle(i);
      addr[i] = '0;
      dout[i] = '0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_data_in", din[i], 8'hFF);
      chk("rst_wait_n", wn[i], 1);
      chk("rst_strobes", {rs[i], ws[i]}, 0);
      chk_regs(i);
    end

    for (int i = 0; i < N; i++) begin
      @(posedge clk); #1;
      ld_en   = 1'b1;
      ld_addr = 16'(i);
      ld_data = 8'($urandom);
      mdl[0][i] = ld_data;
      mdl[1][i] = ld_data;
    end
    @(posedge clk); #1;
    ld_addr = 16'hF123;
    ld_data = 8'h5A;
    mdl[0][12'h123] = 8'h5A;
    mdl[1][12'h123] = 8'h5A;
    @(posedge clk); #1;
    ld_en = 1'b0;

    for (int i = 0; i < 9; i++)
      cycle(tv[i].d, tv[i].wr, tv[i].m1, tv[i].a,
            tv[i].wd, 1'b0, 8'h00, tv[i].ew,
            tv[i].erd);

    // preload racing a read, then a write
    old = mdl[0][12'h555];
    cycle(0, 0, 0, 16'h0555, 8'h00, 1, 8'hE7, 0, old);
    cycle(0, 0, 0, 16'h0555, 8'h00, 0, 8'h00, 0, 8'hE7);
    cycle(1, 1, 0, 16'h0666, 8'h11, 1, 8'h22, 2, 8'h00);
    cycle(1, 0, 0, 16'h0666, 8'h00, 0, 8'h00, 2, 8'h11);
    cycle(0, 0, 0, 16'h0666, 8'h00, 0, 8'h00, 0, 8'h22);

    // refresh is ignored
    @(posedge clk); #1;
    addr[1]   = 16'h0040;
    rd_n[1]   = 1'b0;
    rfsh_n[1] = 1'b0;
    mreq_n[1] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rfsh_wait_n", wn[1], 1);
      chk("rfsh_strobes", {rs[1], ws[1]}, 0);
    end
    bus_idle(1);
    cycle(1, 0, 1, 16'h0040, 8'h00, 0, 8'h00, 1,
          mdl[1][12'h040]);

    for (int i = 0; i < 80; i++) begin
      d   = int'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      m1  = !wr && 1'($urandom_range(0, 1));
      a   = 16'($urandom);
      wd  = 8'($urandom);
      xld = ($urandom_range(0, 3) == 0);
      xd  = 8'($urandom);
      cycle(d, wr, m1, a, wd, xld, xd,
            exp_waits(d, m1), mdl[d][a[AB-1:0]]);
    end

`ifdef Z80_MEM_ROM_PROTECT_EN
    cycle(0, 1, 0, 16'h0010, 8'hFF, 0, 8'h00, 0, 8'h00);
    cycle(0, 0, 0, 16'h0010, 8'h00, 0, 8'h00, 0,
          mdl[0][12'h010]);
    cycle(0, 1, 0, 16'h0100, 8'h42, 0, 8'h00, 0, 8'h00);
    cycle(0, 0, 0, 16'h0100, 8'h00, 0, 8'h00, 0, 8'h42);
`endif

    // rd_n and wr_n both low
    @(posedge clk); #1;
    addr[0]   = 16'h0300;
    dout[0]   = ~mdl[0][12'h300];
    rd_n[0]   = 1'b0;
    wr_n[0]   = 1'b0;
    mreq_n[0] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("both_wait_n", wn[0], 1);
      chk("both_strobes", {rs[0], ws[0]}, 0);
    end
    bus_idle(0);
    m_pe[0] = 1'b1;
    @(posedge clk); #1;
    chk_regs(0);
    cycle(0, 0, 0, 16'h0300, 8'h00, 0, 8'h00, 0,
          mdl[0][12'h300]);

    // mreq_n dropped during WAIT
    @(posedge clk); #1;
    addr[1]   = 16'h0777;
    rd_n[1]   = 1'b0;
    mreq_n[1] = 1'b0;
    @(posedge clk); #1;
    chk("abort_pre_wait_n", wn[1], 0);
    bus_idle(1);
    m_pe[1] = 1'b1;
    @(posedge clk); #1;
    chk("abort_wait_n", wn[1], 1);
    chk("abort_strobes", {rs[1], ws[1]}, 0);
    chk_regs(1);

    // reset asserted mid-WAIT of a write
    old = mdl[1][12'h200];
    @(posedge clk); #1;
    addr[1]   = 16'h0200;
    dout[1]   = ~old;
    wr_n[1]   = 1'b0;
    mreq_n[1] = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_wait_n", wn[1], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_wait_n", wn[1], 1);
    chk("rst_mid_strobes", {rs[1], ws[1]}, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus_idle(1);
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst2_data_in", din[i], 8'hFF);
      chk_regs(i);
    end
    cycle(1, 0, 0, 16'h0200, 8'h00, 0, 8'h00, 2, old);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
